// File: rtl/job_tx.sv
// Job frame transmitter: serializes one wide job word into NBYTES UART bytes, MSB byte first,
// handshaking with a UART through a transmit pulse and its is_transmitting flag.
module job_tx #(
    parameter int unsigned NBYTES       = 80,
    parameter int unsigned GAP_CYCLES   = 16,
    parameter int unsigned BUSY_TIMEOUT = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [8*NBYTES-1:0] job_in_i,
    input  logic                tx_busy_i,
    output logic                transmit_o,
    output logic [7:0]          tx_byte_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [6:0]          byte_cnt_o
);

    localparam int unsigned JobW = 8 * NBYTES;
    localparam int unsigned TmoW = $clog2(BUSY_TIMEOUT + 1);
    localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [TmoW-1:0] TmoLast = TmoW'(BUSY_TIMEOUT - 1);
    localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [6:0]      CntLast = 7'(NBYTES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWaitHi,
        StWaitLo,
        StGap,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [JobW-1:0]   shreg_q, shreg_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic [6:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic              byte_end;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            tx_byte_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            tx_byte_q <= tx_byte_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        tx_byte_d = tx_byte_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        byte_end  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i && !tx_busy_i) begin
                    shreg_d = job_in_i;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = StArm;
                end
            end
            StArm: begin
                tx_byte_d = shreg_q[JobW-1 -: 8];
                tmo_d     = '0;
                state_d   = StWaitHi;
            end
            StWaitHi: begin
                if (tx_busy_i) begin
                    state_d = StWaitLo;
                end else if (tmo_q == TmoLast) begin
                    // UART never acknowledged: flag it and treat the byte as sent
                    err_d    = 1'b1;
                    byte_end = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StWaitLo: begin
                if (!tx_busy_i) begin
                    byte_end = 1'b1;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StArm;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (byte_end) begin
            shreg_d = shreg_q << 8;
            if (cnt_q == CntLast) begin
                state_d = StDone;
            end else begin
                cnt_d   = cnt_q + 7'd1;
                gap_d   = '0;
                state_d = (GAP_CYCLES == 0) ? StArm : StGap;
            end
        end
    end

    // In ARM the byte comes straight from the shift register; it is held afterwards.
    assign transmit_o = (state_q == StArm);
    assign tx_byte_o  = (state_q == StArm) ? shreg_q[JobW-1 -: 8] : tx_byte_q;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StDone);
    assign error_o    = err_q;
    assign byte_cnt_o = cnt_q;

endmodule
